// File: rtl/lock_countdown_3to0.sv
// Lock-out countdown timer: counts START_VALUE down to 0, one step every STEP_CYCLES clocks,
// shows the remaining count as a thermometer code on four LEDs and raises rst_all at zero.
module lock_countdown_3to0 #(
  parameter int unsigned START_VALUE = 3,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,      // synchronous, active-low
  output logic [3:0] led,
  output logic       rst_all
);

  localparam int unsigned PrescW = $clog2(STEP_CYCLES) + 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(STEP_CYCLES - 1);
  localparam logic [2:0] StartCount = 3'(START_VALUE);
  localparam logic [3:0] StartLed = 4'((1 << START_VALUE) - 1);

  // Elaboration-time parameter range checks
  if (START_VALUE < 1 || START_VALUE > 4) begin : g_bad_start
    $error("lock_countdown_3to0: START_VALUE must be in 1..4");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("lock_countdown_3to0: STEP_CYCLES must be >= 1");
  end

  typedef enum logic {StCounting, StExpired} state_e;

  state_e              state_q, state_d;
  logic [2:0]          count_q, count_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [3:0]          led_q, led_d;
  logic                rst_all_q, rst_all_d;

  // Next-state: prescale, decrement, and freeze everything once expired
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    unique case (state_q)
      StCounting: begin
        if (presc_q == PrescMax) begin
          presc_d = '0;
          count_d = count_q - 3'd1;
          if (count_q == 3'd1) begin
            state_d = StExpired;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StExpired: ;
      default: state_d = StExpired;
    endcase
    // Outputs are registered copies of the next count/state so they line up with the update edge
    for (int unsigned i = 0; i < 4; i++) begin
      led_d[i] = (3'(i) < count_d);
    end
    rst_all_d = (state_d == StExpired);
  end

  // State register with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StCounting;
      count_q   <= StartCount;
      presc_q   <= '0;
      led_q     <= StartLed;
      rst_all_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
      rst_all_q <= rst_all_d;
    end
  end

  assign led     = led_q;
  assign rst_all = rst_all_q;

endmodule

// File: tb/tb_lock_countdown_3to0.sv
module tb_lock_countdown_3to0;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] led_a, led_b;
  logic       rst_all_a, rst_all_b;

  int checks;
  int failures;
  bit inv_en;

  lock_countdown_3to0 u_dut_a (
    .clk     (clk),
    .rst     (rst_a),
    .led     (led_a),
    .rst_all (rst_all_a)
  );

  lock_countdown_3to0 #(
    .START_VALUE (4),
    .STEP_CYCLES (4)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst_b),
    .led     (led_b),
    .rst_all (rst_all_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Every edge: rst_all mirrors an all-dark bank and led is a legal thermometer code
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (rst_all_a !== (led_a == 4'b0000)) begin
        failures++;
        $display("FAIL inv_a_rst_all: rst_all=%b led=%b", rst_all_a, led_a);
      end
      checks++;
      if (!(led_a inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
        failures++;
        $display("FAIL inv_a_therm: led=%b not a thermometer code", led_a);
      end
      checks++;
      if (rst_all_b !== (led_b == 4'b0000)) begin
        failures++;
        $display("FAIL inv_b_rst_all: rst_all=%b led=%b", rst_all_b, led_b);
      end
      checks++;
      if (!(led_b inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
        failures++;
        $display("FAIL inv_b_therm: led=%b not a thermometer code", led_b);
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge1();
      inv_en = 1'b1;
      checks++;
      if (led_a !== 4'b0111 || rst_all_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold edge %0d: led=%b rst_all=%b want 0111/0", i, led_a, rst_all_a);
      end
      checks++;
      if (led_b !== 4'b1111 || rst_all_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold_b edge %0d: led=%b rst_all=%b want 1111/0", i, led_b,
                 rst_all_b);
      end
    end
  endtask

  task automatic test_countdown();
    logic [3:0] exp_led [3] = '{4'b0011, 4'b0001, 4'b0000};
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (led_a !== exp_led[i] || rst_all_a !== (i == 2)) begin
        failures++;
        $display("FAIL countdown edge %0d: led=%b rst_all=%b want %b/%0d", i + 1, led_a,
                 rst_all_a, exp_led[i], (i == 2));
      end
    end
    for (int i = 0; i < 10; i++) begin
      edge1();
      checks++;
      if (led_a !== 4'b0000 || rst_all_a !== 1'b1) begin
        failures++;
        $display("FAIL expired_hold edge %0d: led=%b rst_all=%b want 0000/1", i, led_a,
                 rst_all_a);
      end
    end
  endtask

  task automatic test_reset_expired();
    rst_a = 1'b0;
    edge1();
    checks++;
    if (led_a !== 4'b0111 || rst_all_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_expired: led=%b rst_all=%b want 0111/0", led_a, rst_all_a);
    end
    rst_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_led [3] = '{4'b0011, 4'b0001, 4'b0000};
    edge1();
    edge1();
    checks++;
    if (led_a !== 4'b0001) begin
      failures++;
      $display("FAIL mid_pre: led=%b want 0001", led_a);
    end
    rst_a = 1'b0;
    edge1();
    checks++;
    if (led_a !== 4'b0111 || rst_all_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: led=%b rst_all=%b want 0111/0", led_a, rst_all_a);
    end
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (led_a !== exp_led[i] || rst_all_a !== (i == 2)) begin
        failures++;
        $display("FAIL mid_restart edge %0d: led=%b rst_all=%b want %b/%0d", i + 1, led_a,
                 rst_all_a, exp_led[i], (i == 2));
      end
    end
  endtask

  task automatic test_step4();
    int         cnt;
    logic [3:0] want;
    rst_b = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      edge1();
      cnt  = (k >= 16) ? 0 : 4 - k / 4;
      want = 4'((1 << cnt) - 1);
      checks++;
      if (led_b !== want || rst_all_b !== (cnt == 0)) begin
        failures++;
        $display("FAIL step4 edge %0d: led=%b rst_all=%b want %b/%0d", k, led_b, rst_all_b,
                 want, (cnt == 0));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    inv_en   = 1'b0;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    test_reset();
    test_countdown();
    test_reset_expired();
    test_reset_mid();
    test_step4();
    edge1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
